// File: rtl/adc_scan_pkg.sv
// Shared constants for the ADC scan sequencer: state encoding, channel count,
// controller WD/RDL field positions and the averaging depth.
package adc_scan_pkg;

  localparam int unsigned NCHAN     = 32;
  localparam int unsigned CH_W      = $clog2(NCHAN);
  localparam int unsigned AVG_COUNT = 4;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCHAN - 1);

  // WD command byte: {3'b000, device, input}
  localparam int unsigned WD_DEV_MSB = 4;
  localparam int unsigned WD_DEV_LSB = 3;
  localparam int unsigned WD_IN_MSB  = 2;
  localparam int unsigned WD_IN_LSB  = 0;

  // RDL status byte: {result[3:0], 0, channel, busy}
  localparam int unsigned RDL_BUSY_BIT = 0;
  localparam int unsigned RDL_RES_MSB  = 7;
  localparam int unsigned RDL_RES_LSB  = 4;

  // Scan FSM encoding
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFind  = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StArm   = 3'd3;
  localparam logic [2:0] StWaitb = 3'd4;
  localparam logic [2:0] StStore = 3'd5;
  localparam logic [2:0] StGap   = 3'd6;

  // Build the convert command byte for a flat channel number.
  function automatic logic [7:0] wd_encode(input logic [CH_W-1:0] ch);
    logic [7:0] wd;
    wd = '0;
    wd[WD_DEV_MSB:WD_DEV_LSB] = ch[4:3];
    wd[WD_IN_MSB:WD_IN_LSB]   = ch[2:0];
    return wd;
  endfunction

endpackage

// File: rtl/adc_result_regfile.sv
// 32 x 12-bit conversion result store: one synchronous write port, one
// combinational read port, all entries cleared by RESET.
module adc_result_regfile
  import adc_scan_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            we,
  input  logic [CH_W-1:0] waddr,
  input  logic [11:0]     wdata,
  input  logic [CH_W-1:0] raddr,
  output logic [11:0]     rdata
);

  logic [11:0] mem_q [NCHAN];

  // Result storage with asynchronous clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NCHAN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read for the CPU
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Autonomous channel-mask scan engine in front of the MAX1202 SPI controller.
// Issues one convert per enabled channel, polls busy, stores 12-bit results.
// Optional feature: define ADC_SCAN_AVG_EN to convert each channel AVG_COUNT
// times and store the mean of the 14-bit sum.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             CONT,
  input  logic [NCHAN-1:0] MASK,
  output logic             BUSY,
  output logic             DONE,
  output logic [NCHAN-1:0] VALID,
  output logic             DWE,
  output logic [7:0]       WD,
  input  logic [7:0]       RDH,
  input  logic [7:0]       RDL,
  input  logic [CH_W-1:0]  RADDR,
  output logic [11:0]      RDATA
);

  // GAP lasts GAP_CYCLES cycles: load N-1 and leave on zero
  localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [3:0]       gap_q, gap_d;
  logic [NCHAN-1:0] valid_q, valid_d;
  logic [7:0]       wd_q, wd_d;
  logic             busy_q, done_q, done_d, dwe_q;
  logic             rf_we;
  logic [11:0]      rf_wdata;
  logic [11:0]      result;
  logic             unused_rdl;

  assign result     = {RDH, RDL[RDL_RES_MSB:RDL_RES_LSB]};
  assign unused_rdl = ^RDL[RDL_RES_LSB-1:RDL_BUSY_BIT+1];

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]  avg_q, avg_d;
  logic [13:0] acc_q, acc_d, acc_sum;
  logic        unused_acc;

  assign acc_sum    = acc_q + {2'b00, result};
  assign unused_acc = ^acc_sum[1:0];

  // Accumulator and conversion count for the current channel
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      avg_q <= '0;
      acc_q <= '0;
    end else begin
      avg_q <= avg_d;
      acc_q <= acc_d;
    end
  end
`endif

  // Next-state and datapath decisions for the scan FSM
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    gap_d    = gap_q;
    valid_d  = valid_q;
    wd_d     = wd_q;
    done_d   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = result;
`ifdef ADC_SCAN_AVG_EN
    avg_d    = avg_q;
    acc_d    = acc_q;
`endif
    case (state_q)
      StIdle: begin
        // A restart after DONE is gated by CONT; START while busy never reaches here
        if (START || (CONT && done_q)) begin
          mask_d  = MASK;
          valid_d = '0;
          ch_d    = '0;
          state_d = StFind;
`ifdef ADC_SCAN_AVG_EN
          avg_d   = '0;
          acc_d   = '0;
`endif
        end
      end
      StFind: begin
        if (mask_q[ch_q]) begin
          wd_d    = wd_encode(ch_q);
          state_d = StIssue;
        end else if (ch_q == LAST_CH) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      StIssue: state_d = StArm;
      // Controller needs a cycle before busy is meaningful
      StArm:   state_d = StWaitb;
      StWaitb: begin
        if (!RDL[RDL_BUSY_BIT]) begin
          state_d = StStore;
        end
      end
      StStore: begin
`ifdef ADC_SCAN_AVG_EN
        if (avg_q != 2'(AVG_COUNT - 1)) begin
          // More conversions of the same channel; FIND re-selects it
          acc_d   = acc_sum;
          avg_d   = avg_q + 1'b1;
          gap_d   = GapLoad;
          state_d = StGap;
        end else begin
          rf_we         = 1'b1;
          rf_wdata      = acc_sum[13:2];
          valid_d[ch_q] = 1'b1;
          acc_d         = '0;
          avg_d         = '0;
          if (ch_q == LAST_CH) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            ch_d    = ch_q + 1'b1;
            gap_d   = GapLoad;
            state_d = StGap;
          end
        end
`else
        rf_we         = 1'b1;
        valid_d[ch_q] = 1'b1;
        if (ch_q == LAST_CH) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          ch_d    = ch_q + 1'b1;
          gap_d   = GapLoad;
          state_d = StGap;
        end
`endif
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StFind;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan state and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      ch_q    <= '0;
      mask_q  <= '0;
      gap_q   <= '0;
      valid_q <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
      dwe_q   <= (state_d == StIssue);
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign VALID = valid_q;
  assign DWE   = dwe_q;
  assign WD    = wd_q;

  adc_result_regfile u_regfile (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (rf_we),
    .waddr (ch_q),
    .wdata (rf_wdata),
    .raddr (RADDR),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer with a simple MAX1202 controller
// model and queue-based scoreboards for commands and results.
module tb_adc_scan_sequencer;

`ifdef ADC_SCAN_AVG_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif
  localparam int CONV_LAT = 5;

  logic        CLK, RESET, START, CONT;
  logic [31:0] MASK, VALID;
  logic        BUSY, DONE, DWE;
  logic [7:0]  WD, RDH, RDL;
  logic [4:0]  RADDR;
  logic [11:0] RDATA;

  int checks = 0;
  int errors = 0;

  logic [11:0] resp_q[$];   // values the controller model will return
  logic [7:0]  exp_wd[$];   // expected command stream
  logic [7:0]  obs_wd[$];   // observed command stream

  adc_scan_sequencer #(.GAP_CYCLES(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .CONT  (CONT),
    .MASK  (MASK),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .VALID (VALID),
    .DWE   (DWE),
    .WD    (WD),
    .RDH   (RDH),
    .RDL   (RDL),
    .RADDR (RADDR),
    .RDATA (RDATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Controller model: busy rises two cycles after DWE, lasts CONV_LAT cycles
  logic        ctl_pend;
  int          ctl_cnt;
  logic [11:0] ctl_res;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctl_pend <= 1'b0;
      ctl_cnt  <= 0;
      ctl_res  <= '0;
    end else begin
      ctl_pend <= DWE;
      if (DWE) begin
        if (resp_q.size() > 0) ctl_res <= resp_q.pop_front();
        else ctl_res <= 12'hFFF;
      end
      if (ctl_pend) ctl_cnt <= CONV_LAT;
      else if (ctl_cnt > 0) ctl_cnt <= ctl_cnt - 1;
    end
  end
  assign RDH = ctl_res[11:4];
  assign RDL = {ctl_res[3:0], 1'b0, 2'b00, (ctl_cnt > 0)};

  // Record every command the DUT issues
  always @(negedge CLK) begin
    if (!RESET && DWE) obs_wd.push_back(WD);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_chan(input logic [4:0] ch, input logic [11:0] val);
    for (int i = 0; i < REPS; i++) begin
      exp_wd.push_back({3'b000, ch});
      resp_q.push_back(val);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge CLK);
      cycles++;
      if (DONE) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++; if (DWE !== 1'b0) begin errors++; $display("FAIL reset_dwe: got %b want 0", DWE); end
    checks++; if (WD !== 8'h00) begin errors++; $display("FAIL reset_wd: got %h want 00", WD); end
    checks++; if (VALID !== 32'h0) begin errors++; $display("FAIL reset_valid: got %h want 0", VALID); end
    RADDR = 5'd0; #1;
    checks++; if (RDATA !== 12'h000) begin errors++; $display("FAIL reset_rdata: got %h want 000", RDATA); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int cyc; bit ok; logic [7:0] e, o;
    MASK = 32'h0000_0001;
    push_chan(5'd0, 12'hABC);
    pulse_start();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b want 1", BUSY); end
    wait_done(500, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got no DONE want DONE"); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", BUSY); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", DONE); end
    checks++; if (VALID !== 32'h1) begin errors++; $display("FAIL single_valid: got %h want 1", VALID); end
    RADDR = 5'd0; #1;
    checks++; if (RDATA !== 12'hABC) begin errors++; $display("FAIL single_rdata: got %h want abc", RDATA); end
    checks++;
    if (obs_wd.size() != exp_wd.size()) begin
      errors++; $display("FAIL single_dwe_count: got %0d want %0d", obs_wd.size(), exp_wd.size());
    end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = obs_wd.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_wd: got %h want %h", o, e); end
    end
    exp_wd.delete(); obs_wd.delete();
  endtask

  task automatic test_multi();
    int cyc; bit ok; logic [7:0] e, o;
    MASK = 32'h8000_0101;
    push_chan(5'd0, 12'h123);
    push_chan(5'd8, 12'h456);
    push_chan(5'd31, 12'h789);
    pulse_start();
    checks++; if (VALID !== 32'h0) begin errors++; $display("FAIL multi_valid_clear: got %h want 0", VALID); end
    wait_done(3000, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_done_timeout: got no DONE want DONE"); end
    checks++; if (VALID !== 32'h8000_0101) begin errors++; $display("FAIL multi_valid: got %h want 80000101", VALID); end
    RADDR = 5'd0; #1;
    checks++; if (RDATA !== 12'h123) begin errors++; $display("FAIL multi_rdata0: got %h want 123", RDATA); end
    RADDR = 5'd8; #1;
    checks++; if (RDATA !== 12'h456) begin errors++; $display("FAIL multi_rdata8: got %h want 456", RDATA); end
    RADDR = 5'd31; #1;
    checks++; if (RDATA !== 12'h789) begin errors++; $display("FAIL multi_rdata31: got %h want 789", RDATA); end
    RADDR = 5'd1; #1;
    checks++; if (RDATA !== 12'h000) begin errors++; $display("FAIL multi_rdata1: got %h want 000", RDATA); end
    checks++;
    if (obs_wd.size() != exp_wd.size()) begin
      errors++; $display("FAIL multi_dwe_count: got %0d want %0d", obs_wd.size(), exp_wd.size());
    end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = obs_wd.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL multi_wd: got %h want %h", o, e); end
    end
    exp_wd.delete(); obs_wd.delete();
  endtask

  task automatic test_zero_mask();
    int cyc; bit ok;
    MASK = 32'h0;
    pulse_start();
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout: got no DONE want DONE"); end
    checks++; if (cyc != 32) begin errors++; $display("FAIL zero_done_latency: got %0d want 32", cyc); end
    checks++; if (VALID !== 32'h0) begin errors++; $display("FAIL zero_valid: got %h want 0", VALID); end
    checks++; if (obs_wd.size() != 0) begin errors++; $display("FAIL zero_dwe_count: got %0d want 0", obs_wd.size()); end
    obs_wd.delete();
  endtask

  task automatic test_start_cont();
    int cyc; bit ok; logic [7:0] e, o;
    MASK = 32'h0000_0003;
    CONT = 1'b1;
    push_chan(5'd0, 12'h011);
    push_chan(5'd1, 12'h022);
    push_chan(5'd0, 12'h033);
    push_chan(5'd1, 12'h044);
    pulse_start();
    repeat (3) @(negedge CLK);
    MASK  = 32'hFFFF_FFFF;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    MASK = 32'h0000_0003;
    wait_done(3000, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_done1_timeout: got no DONE want DONE"); end
    checks++; if (VALID !== 32'h3) begin errors++; $display("FAIL cont_valid1: got %h want 3", VALID); end
    RADDR = 5'd1; #1;
    checks++; if (RDATA !== 12'h022) begin errors++; $display("FAIL cont_rdata1a: got %h want 022", RDATA); end
    @(negedge CLK);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL cont_restart_busy: got %b want 1", BUSY); end
    checks++; if (VALID !== 32'h0) begin errors++; $display("FAIL cont_restart_valid: got %h want 0", VALID); end
    CONT = 1'b0;
    wait_done(3000, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_done2_timeout: got no DONE want DONE"); end
    RADDR = 5'd0; #1;
    checks++; if (RDATA !== 12'h033) begin errors++; $display("FAIL cont_rdata0b: got %h want 033", RDATA); end
    RADDR = 5'd1; #1;
    checks++; if (RDATA !== 12'h044) begin errors++; $display("FAIL cont_rdata1b: got %h want 044", RDATA); end
    repeat (6) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b want 0", BUSY); end
    checks++;
    if (obs_wd.size() != exp_wd.size()) begin
      errors++; $display("FAIL cont_dwe_count: got %0d want %0d", obs_wd.size(), exp_wd.size());
    end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = obs_wd.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL cont_wd: got %h want %h", o, e); end
    end
    exp_wd.delete(); obs_wd.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    MASK = 32'h0000_0001;
    push_chan(5'd0, 12'h5A5);
    pulse_start();
    n = 0;
    while (!DWE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++; if (DWE !== 1'b1) begin errors++; $display("FAIL rstmid_dwe_timeout: got %b want 1", DWE); end
    repeat (2) @(negedge CLK);   // now in WAITB with busy high
    RESET = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
    checks++; if (DWE !== 1'b0) begin errors++; $display("FAIL rstmid_dwe: got %b want 0", DWE); end
    checks++; if (VALID !== 32'h0) begin errors++; $display("FAIL rstmid_valid: got %h want 0", VALID); end
    checks++; if (WD !== 8'h00) begin errors++; $display("FAIL rstmid_wd: got %h want 00", WD); end
    for (int a = 0; a < 32; a++) begin
      RADDR = 5'(a); #1;
      checks++;
      if (RDATA !== 12'h000) begin errors++; $display("FAIL rstmid_rdata%0d: got %h want 000", a, RDATA); end
    end
    @(negedge CLK);
    RESET = 1'b0;
    resp_q.delete(); exp_wd.delete(); obs_wd.delete();
    @(negedge CLK);
  endtask

  task automatic test_avg();
`ifdef ADC_SCAN_AVG_EN
    int cyc; bit ok; logic [7:0] e, o;
    MASK = 32'h0000_0010;
    for (int i = 0; i < 4; i++) begin
      exp_wd.push_back(8'h04);
      resp_q.push_back(12'(100 + i));
    end
    pulse_start();
    wait_done(3000, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL avg_done_timeout: got no DONE want DONE"); end
    checks++; if (VALID !== 32'h10) begin errors++; $display("FAIL avg_valid: got %h want 10", VALID); end
    RADDR = 5'd4; #1;
    checks++; if (RDATA !== 12'd101) begin errors++; $display("FAIL avg_rdata: got %0d want 101", RDATA); end
    checks++;
    if (obs_wd.size() != exp_wd.size()) begin
      errors++; $display("FAIL avg_dwe_count: got %0d want %0d", obs_wd.size(), exp_wd.size());
    end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      e = exp_wd.pop_front(); o = obs_wd.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL avg_wd: got %h want %h", o, e); end
    end
    exp_wd.delete(); obs_wd.delete();
`endif
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    CONT  = 1'b0;
    MASK  = 32'h0;
    RADDR = 5'd0;
    test_reset();
    test_single();
    test_multi();
    test_zero_mask();
    test_start_cont();
    test_reset_mid();
    test_avg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
